wb_master_bridge: RTL



---
 rtl/wb_pkg.sv | 22 ++
 rtl/wb_ack_timer.sv | 42 ++++
 rtl/wb_master_bridge.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the Wishbone master bridge and related bus masters.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_state_e;

  localparam logic [31:0] ADDR_BASE_DEF = 32'h3000_0000;
  localparam logic [31:0] ADDR_MASK_DEF = 32'hFFFF_FF00;

  localparam logic RSP_OK  = 1'b0;
  localparam logic RSP_ERR = 1'b1;

  function automatic logic in_window(input logic [31:0] adr,
                                     input logic [31:0] base,
                                     input logic [31:0] mask);
    return (adr & mask) == base;
  endfunction

endpackage

// File: rtl/wb_ack_timer.sv
// Clearable ack-wait counter; pulses expire_o in the cycle the count would reach LIMIT.
module wb_ack_timer #(
  parameter int unsigned TO_W  = 8,
  parameter int unsigned LIMIT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [TO_W-1:0] LAST = TO_W'(LIMIT - 1);
  localparam logic [TO_W-1:0] ONE  = {{(TO_W-1){1'b0}}, 1'b1};

  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;

  // Next count: clear has priority over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/wb_master_bridge.sv
// Single-outstanding Wishbone classic master: one command becomes one bus cycle and one response.
module wb_master_bridge
  import wb_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE      = ADDR_BASE_DEF,
  parameter logic [31:0] ADDR_MASK      = ADDR_MASK_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_W           = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        busy
);

  wb_state_e   state_q;
  logic        cyc_q, stb_q, we_q;
  logic [3:0]  sel_q;
  logic [31:0] adr_q, dat_q;
  logic        rsp_valid_q, rsp_err_q;
  logic [31:0] rsp_dat_q;
  logic        cmd_ready_q, busy_q;

  logic        to_en_s, to_clr_s, to_expire_s;

  assign to_en_s  = (state_q == BUS) && !wbm_ack_i;
  assign to_clr_s = (state_q == RESP) && rsp_ready;

  wb_ack_timer #(
    .TO_W  (TO_W),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i    (wb_clk_i),
    .rst_i    (wb_rst_i),
    .clr_i    (to_clr_s),
    .en_i     (to_en_s),
    .expire_o (to_expire_s)
  );

  // Bridge FSM with all outputs registered; ack beats a same-cycle timeout.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= 4'h0;
      adr_q       <= 32'h0;
      dat_q       <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= RSP_OK;
      rsp_dat_q   <= 32'h0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            we_q        <= cmd_we;
            adr_q       <= cmd_adr;
            dat_q       <= cmd_dat;
            sel_q       <= cmd_sel;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (in_window(cmd_adr, ADDR_BASE, ADDR_MASK)) begin
              state_q <= BUS;
              cyc_q   <= 1'b1;
              stb_q   <= 1'b1;
            end else begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= RSP_ERR;
              rsp_dat_q   <= 32'h0;
            end
          end
        end
        BUS: begin
          if (wbm_ack_i) begin
            state_q     <= RESP;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= RSP_OK;
            rsp_dat_q   <= we_q ? 32'h0 : wbm_dat_i;
          end else if (to_expire_s) begin
            state_q     <= RESP;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= RSP_ERR;
            rsp_dat_q   <= 32'h0;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          cyc_q       <= 1'b0;
          stb_q       <= 1'b0;
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_dat   = rsp_dat_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = stb_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;

endmodule
